// File: rtl/mul_add_u.sv
// Iterative unsigned multiply-accumulate: {hi,lo} = a*b + c, one shift-add step per clock.
// Used to recombine quotient*divisor + remainder from the sequential divider.
module mul_add_u #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic             last_step;

  // acc_hi starts at c, so the addend rides along the partial products for free.
  assign sum       = acc_hi_q + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted   = {sum, acc_lo_q} >> 1;
  assign last_step = busy_q && (cnt_q == LAST);

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // A start landing on the final step still retires the finished result.
    if (last_step) begin
      done_d = 1'b1;
      hi_d   = shifted[2*WIDTH-1:WIDTH];
      lo_d   = shifted[WIDTH-1:0];
    end

    if (start) begin
      acc_hi_d = {1'b0, c};
      acc_lo_d = b;
      mcand_d  = a;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_hi_d = shifted[2*WIDTH:WIDTH];
      acc_lo_d = shifted[WIDTH-1:0];
      cnt_d    = cnt_q + CW'(1);
      if (last_step) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_add_u.sv
// Directed bench for mul_add_u (WIDTH=32): vector table plus restart and reset-abort sequences.
module tb_mul_add_u;
  localparam int W = 32;

  logic         clock, reset, start;
  logic [W-1:0] a, b, c;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] prev_hi, prev_lo;

  mul_add_u #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .a(a), .b(b), .c(c),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [W-1:0] a, b, c;
    logic [W-1:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue a one-cycle start; returns at the first sample after the start edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc);
    @(negedge clock);
    start = 1'b1; a = ta; b = tb_; c = tc;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; c = $urandom;
  endtask

  // Wait for done; checks latency, busy length, result, held value and done width.
  task automatic wait_result(input string name, input logic [W-1:0] eh, input logic [W-1:0] el,
                             input bit check_hold);
    int lat = 1;
    int nbusy = 0;
    int bad_hold = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      if (check_hold && (hi !== prev_hi || lo !== prev_lo)) bad_hold++;
      @(negedge clock);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(W + 1));
    check({name, " busy_cycles"}, 64'(nbusy), 64'(W));
    check({name, " busy_low_at_done"}, 64'(busy), 64'(0));
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    if (check_hold) check({name, " prev_result_held"}, 64'(bad_hold), 64'(0));
    @(negedge clock);
    check({name, " done_one_cycle"}, 64'(done), 64'(0));
    check({name, " result_held"}, {hi, lo}, {eh, el});
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int errs;
    int seen_done;

    vecs[0]  = '{"small",       32'd7,          32'd6,          32'd5,          32'h0,        32'h2F};
    vecs[1]  = '{"all_ones_c",  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h0};
    vecs[2]  = '{"msb_times2",  32'h80000000,   32'd2,          32'd0,          32'h1,        32'h0};
    vecs[3]  = '{"div_rt",      32'd14,         32'd7,          32'd2,          32'h0,        32'd100};
    vecs[4]  = '{"div_rt_big",  32'h0000FFFF,   32'h00010001,   32'h00001234,   32'h1,        32'h00001233};
    vecs[5]  = '{"zeros",       32'd0,          32'd0,          32'd0,          32'h0,        32'h0};
    vecs[6]  = '{"c_only",      32'd0,          32'd0,          32'hFFFFFFFF,   32'h0,        32'hFFFFFFFF};
    vecs[7]  = '{"times_one",   32'hDEADBEEF,   32'd1,          32'd0,          32'h0,        32'hDEADBEEF};
    vecs[8]  = '{"shift4_add",  32'h12345678,   32'h10,         32'd9,          32'h1,        32'h23456789};
    vecs[9]  = '{"max_sq",      32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'hFFFFFFFE, 32'h00000001};
    vecs[10] = '{"pow2_sq",     32'h00010000,   32'h00010000,   32'd0,          32'h1,        32'h0};

    reset = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
    prev_hi = '0; prev_lo = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) errs++;
    end
    check("reset_idle", 64'(errs), 64'(0));

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].c);
      wait_result(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
    end

    // Restart at cycle 10: first op abandoned, old result held until the new one lands.
    start_op(32'd3, 32'd3, 32'd0);
    seen_done = 0;
    errs = 0;
    for (int i = 0; i < 9; i++) begin
      if (done) seen_done++;
      if (hi !== prev_hi || lo !== prev_lo) errs++;
      @(negedge clock);
    end
    check("restart_no_early_done", 64'(seen_done), 64'(0));
    check("restart_hold_before", 64'(errs), 64'(0));
    start_op(32'd5, 32'd5, 32'd1);
    wait_result("restart", 32'h0, 32'd26, 1'b1);

    // Reset mid-operation aborts without a done pulse and clears the result.
    start_op(32'd9, 32'd9, 32'd0);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_result", {hi, lo}, 64'(0));
    reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    check("rst_mid_no_done", 64'(seen_done), 64'(0));
    start_op(32'd2, 32'd3, 32'd4);
    wait_result("after_reset", 32'h0, 32'd10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
